// File: rtl/lsq_data_memory.sv
// Data-memory responder for the load/store queue.
// Each accepted load or store runs against an internal word array. A tagged
// response comes back after LATENCY cycles through a fixed-length pipeline.
// A stalled response freezes the whole pipeline. The same stall condition
// back-pressures the queue through reqReady.
module lsq_data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] pcMem,
    input  logic [31:0] addressMem,
    input  logic        loadStoreMem,
    input  logic        storeSizeMem,
    input  logic [31:0] swDataMem,
    input  logic [5:0]  ROBNumMem,
    input  logic [5:0]  destRegMem,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] pcOut,
    output logic [5:0]  ROBNumOut,
    output logic [5:0]  destRegOut,
    output logic [31:0] lwData,
    output logic        loadStoreOut
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Contents of one response-pipeline stage
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic [31:0] data;
        logic        is_load;
    } stage_t;

    logic [31:0] mem [DEPTH_WORDS];
    stage_t      stage_reg [LATENCY];
    stage_t      in_stage;

    logic          advance;
    logic          accept;
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_lane;
    logic          unused_addr_bits;

    // The upper address bits are dropped, so addresses wrap around the array.
    assign word_idx         = addressMem[AW+1:2];
    assign byte_lane        = addressMem[1:0];
    assign unused_addr_bits = ^addressMem[31:AW+2];

    // The whole pipeline moves unless the head response is stuck at the consumer
    assign advance  = !respValid || respReady;
    assign reqReady = advance;
    assign accept   = reqValid && advance;

    // Stores write at the accept edge, so any later load sees the new value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && !loadStoreMem) begin
            if (storeSizeMem) begin
                mem[word_idx][{byte_lane, 3'b000} +: 8] <= swDataMem[7:0];
            end else begin
                mem[word_idx] <= swDataMem;
            end
        end
    end

    // Build stage 0 from the accepted request; an empty slot becomes an all-zero bubble
    always_comb begin
        in_stage = '0;
        if (accept) begin
            in_stage.valid   = 1'b1;
            in_stage.pc      = pcMem;
            in_stage.rob     = ROBNumMem;
            in_stage.dest    = destRegMem;
            in_stage.data    = loadStoreMem ? mem[word_idx] : 32'd0;
            in_stage.is_load = loadStoreMem;
        end
    end

    // Fixed-length response shift register: every stage moves together or holds
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_reg[i] <= '0;
            end
        end else if (advance) begin
            stage_reg[0] <= in_stage;
            for (int i = 1; i < LATENCY; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign respValid    = stage_reg[LATENCY-1].valid;
    assign pcOut        = stage_reg[LATENCY-1].pc;
    assign ROBNumOut    = stage_reg[LATENCY-1].rob;
    assign destRegOut   = stage_reg[LATENCY-1].dest;
    assign lwData       = stage_reg[LATENCY-1].data;
    assign loadStoreOut = stage_reg[LATENCY-1].is_load;

endmodule

// File: tb/tb_lsq_data_memory.sv
// Randomised and directed bench for lsq_data_memory.
// The reference model keeps a plain word array and a queue of in-flight
// responses. Each response carries a countdown of the cycles it still needs.
// Two extra instances at LATENCY 1 and 4 check the latency sweep.
module tb_lsq_data_memory;

    localparam int LAT = 2;
    localparam int DW  = 256;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        reqValid = 1'b0;
    logic [31:0] pcMem = '0;
    logic [31:0] addressMem = '0;
    logic        loadStoreMem = 1'b0;
    logic        storeSizeMem = 1'b0;
    logic [31:0] swDataMem = '0;
    logic [5:0]  ROBNumMem = '0;
    logic [5:0]  destRegMem = '0;
    logic        respReady = 1'b1;
    logic        sweep_valid = 1'b0;

    logic        req_ready, resp_valid, ls_out;
    logic [31:0] pc_out, lw_data;
    logic [5:0]  rob_out, dest_out;

    logic        l1_req_ready, l1_valid, l1_ls;
    logic [31:0] l1_pc, l1_data;
    logic [5:0]  l1_rob, l1_dest;
    logic        l4_req_ready, l4_valid, l4_ls;
    logic [31:0] l4_pc, l4_data;
    logic [5:0]  l4_rob, l4_dest;

    always #5 clk = ~clk;

    lsq_data_memory #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn), .reqValid(reqValid), .reqReady(req_ready),
        .pcMem(pcMem), .addressMem(addressMem), .loadStoreMem(loadStoreMem),
        .storeSizeMem(storeSizeMem), .swDataMem(swDataMem), .ROBNumMem(ROBNumMem),
        .destRegMem(destRegMem), .respValid(resp_valid), .respReady(respReady),
        .pcOut(pc_out), .ROBNumOut(rob_out), .destRegOut(dest_out),
        .lwData(lw_data), .loadStoreOut(ls_out)
    );

    lsq_data_memory #(.DEPTH_WORDS(DW), .LATENCY(1)) dut_l1 (
        .clk(clk), .rstn(rstn), .reqValid(sweep_valid), .reqReady(l1_req_ready),
        .pcMem(pcMem), .addressMem(addressMem), .loadStoreMem(loadStoreMem),
        .storeSizeMem(storeSizeMem), .swDataMem(swDataMem), .ROBNumMem(ROBNumMem),
        .destRegMem(destRegMem), .respValid(l1_valid), .respReady(1'b1),
        .pcOut(l1_pc), .ROBNumOut(l1_rob), .destRegOut(l1_dest),
        .lwData(l1_data), .loadStoreOut(l1_ls)
    );

    lsq_data_memory #(.DEPTH_WORDS(DW), .LATENCY(4)) dut_l4 (
        .clk(clk), .rstn(rstn), .reqValid(sweep_valid), .reqReady(l4_req_ready),
        .pcMem(pcMem), .addressMem(addressMem), .loadStoreMem(loadStoreMem),
        .storeSizeMem(storeSizeMem), .swDataMem(swDataMem), .ROBNumMem(ROBNumMem),
        .destRegMem(destRegMem), .respValid(l4_valid), .respReady(1'b1),
        .pcOut(l4_pc), .ROBNumOut(l4_rob), .destRegOut(l4_dest),
        .lwData(l4_data), .loadStoreOut(l4_ls)
    );

    typedef struct {
        int          cnt;
        logic [31:0] pc;
        logic [31:0] data;
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic        ld;
    } ent_t;

    logic [31:0] mdl_mem [DW];
    ent_t        q[$];
    int          checks = 0;
    int          failures = 0;
    bit          acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        q.delete();
        for (int i = 0; i < DW; i++) mdl_mem[i] = '0;
    endtask

    // One clock cycle: drive the request, check the outputs, then update the model at the edge
    task automatic drive_cycle(input bit rv, input bit ld, input bit sz, input logic [31:0] addr,
                               input logic [31:0] dat, input logic [31:0] pc, input logic [5:0] rob,
                               input logic [5:0] dest, input bit rr, output bit accepted);
        bit   exp_valid, adv;
        int   idx;
        ent_t e;
        @(negedge clk);
        reqValid = rv; loadStoreMem = ld; storeSizeMem = sz; addressMem = addr;
        swDataMem = dat; pcMem = pc; ROBNumMem = rob; destRegMem = dest; respReady = rr;
        #1;
        exp_valid = (q.size() > 0) && (q[0].cnt == 0);
        adv = !exp_valid || rr;
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
        chk("req_ready", {31'd0, req_ready}, {31'd0, adv});
        if (exp_valid) begin
            chk("pc_out", pc_out, q[0].pc);
            chk("rob_out", {26'd0, rob_out}, {26'd0, q[0].rob});
            chk("dest_out", {26'd0, dest_out}, {26'd0, q[0].dest});
            chk("lw_data", lw_data, q[0].data);
            chk("ls_out", {31'd0, ls_out}, {31'd0, q[0].ld});
        end
        accepted = rv && adv;
        @(posedge clk);
        if (exp_valid && rr) void'(q.pop_front());
        if (adv) begin
            foreach (q[i]) if (q[i].cnt > 0) q[i].cnt = q[i].cnt - 1;
        end
        if (accepted) begin
            idx = int'(addr[9:2]);
            e.cnt = LAT - 1; e.pc = pc; e.rob = rob; e.dest = dest; e.ld = ld;
            e.data = ld ? mdl_mem[idx] : 32'd0;
            if (!ld) begin
                if (sz) mdl_mem[idx][8*addr[1:0] +: 8] = dat[7:0];
                else    mdl_mem[idx] = dat;
            end
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, acc);
    endtask

    initial begin
        int r, first1, first4;
        clear_model();
        #12;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_lw_data", lw_data, 32'd0);
        chk("rst_rob_dest", {20'd0, rob_out, dest_out}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Store/load round trip
        drive_cycle(1, 0, 0, 32'h4, 32'h23, 32'h10, 6'd1, 6'd0, 1, acc);
        drive_cycle(1, 0, 0, 32'h8, 32'h46, 32'h14, 6'd2, 6'd0, 1, acc);
        drive_cycle(1, 1, 0, 32'h4, 32'h0, 32'h18, 6'd3, 6'd9, 1, acc);
        drive_cycle(1, 1, 0, 32'h8, 32'h0, 32'h1C, 6'd4, 6'd10, 1, acc);
        idle(4);

        // Byte store merges into an existing word
        drive_cycle(1, 0, 0, 32'h20, 32'h11223344, 32'h30, 6'd5, 6'd0, 1, acc);
        drive_cycle(1, 0, 1, 32'h22, 32'h000000AB, 32'h34, 6'd6, 6'd0, 1, acc);
        drive_cycle(1, 1, 0, 32'h20, 32'h0, 32'h38, 6'd7, 6'd11, 1, acc);
        idle(4);

        // Back-pressure: consumer stalls for three cycles while four loads are offered
        r = 0;
        for (int c = 0; c < 30 && (r < 4 || q.size() > 0); c++) begin
            drive_cycle(r < 4, 1, 0, 32'h4 * r, 32'h0, 32'h100 + 32'h4 * r, 6'(10 + r),
                        6'(20 + r), !(c >= 2 && c < 5), acc);
            if (acc) r++;
        end
        chk("bp_all_accepted", r, 4);
        chk("bp_drained", q.size(), 0);

        // Address wrap and forced word alignment
        drive_cycle(1, 0, 0, DW * 4 + 32'h4, 32'hDEADBEEF, 32'h40, 6'd12, 6'd0, 1, acc);
        drive_cycle(1, 1, 0, 32'h7, 32'h0, 32'h44, 6'd13, 6'd14, 1, acc);
        idle(4);

        // Random traffic with random consumer stalls
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom & 32'hFFFFFC00) | $urandom_range(0, 63), $urandom, $urandom,
                        6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                        $urandom_range(0, 3) != 0, acc);
        end
        idle(6);
        chk("rand_drained", q.size(), 0);

        // Reset with two responses in flight
        drive_cycle(1, 1, 0, 32'h8, 32'h0, 32'h200, 6'd30, 6'd31, 1, acc);
        drive_cycle(1, 1, 0, 32'hC, 32'h0, 32'h204, 6'd32, 6'd33, 1, acc);
        @(negedge clk);
        reqValid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_pc_out", pc_out, 32'd0);
        chk("mid_rst_lw_data", lw_data, 32'd0);
        clear_model();
        @(negedge clk);
        rstn = 1'b1;
        idle(3);
        drive_cycle(1, 1, 0, 32'h4, 32'h0, 32'h300, 6'd40, 6'd41, 1, acc);
        idle(4);

        // Latency sweep on the LATENCY 1 and LATENCY 4 instances
        @(negedge clk);
        reqValid = 1'b0; sweep_valid = 1'b1; loadStoreMem = 1'b1; storeSizeMem = 1'b0;
        addressMem = 32'h0; pcMem = 32'hABC; ROBNumMem = 6'd7; destRegMem = 6'd8;
        @(posedge clk);
        #1;
        sweep_valid = 1'b0;
        first1 = -1;
        first4 = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (l1_valid && first1 < 0) begin
                first1 = n;
                chk("lat1_pc", l1_pc, 32'hABC);
            end
            if (l4_valid && first4 < 0) begin
                first4 = n;
                chk("lat4_pc", l4_pc, 32'hABC);
            end
        end
        chk("lat1_first", first1, 0);
        chk("lat4_first", first4, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
